// File: rtl/thermostat_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// thermostat_ctrl_pkg : mode constants and the actuator bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package thermostat_ctrl_pkg;

  localparam logic MODE_COOL = 1'b0;
  localparam logic MODE_HEAT = 1'b1;

  // Field order {heater, aircon, fan} is shared with the actuator drivers.
  typedef struct packed {
    logic heater;
    logic aircon;
    logic fan;
  } actuator_t;

endpackage : thermostat_ctrl_pkg

`default_nettype wire

// File: rtl/thermostat_out_reg.sv
// ---------------------------------------------------------------------------
// thermostat_out_reg : 3-bit actuator register, synchronous active-low clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module thermostat_out_reg
  import thermostat_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  actuator_t act_d,
  output actuator_t act_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end

endmodule : thermostat_out_reg

`default_nettype wire

// File: rtl/thermostat_ctrl.sv
// ---------------------------------------------------------------------------
// thermostat_ctrl : decodes mode/sense flags/fan request into actuator enables
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module thermostat_ctrl
  import thermostat_ctrl_pkg::*;
#(
  parameter bit OUT_REG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic too_cold,
  input  logic too_hot,
  input  logic fan_on,
  output logic heater,
  output logic aircon,
  output logic fan
);

  actuator_t act_d;
  actuator_t act_out;

  // Only the flag matching the mode can request an actuator, so heater and
  // aircon are mutually exclusive by construction.
  always_comb begin
    act_d        = '0;
    act_d.heater = (mode == MODE_HEAT) & too_cold;
    act_d.aircon = (mode == MODE_COOL) & too_hot;
    act_d.fan    = act_d.heater | act_d.aircon | fan_on;
  end

  generate
    if (OUT_REG) begin : g_out_reg
      thermostat_out_reg u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .act_d (act_d),
        .act_q (act_out)
      );
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign act_out        = act_d;
    end
  endgenerate

  assign heater = act_out.heater;
  assign aircon = act_out.aircon;
  assign fan    = act_out.fan;

endmodule : thermostat_ctrl

`default_nettype wire

// File: tb/tb_thermostat_ctrl.sv
// ---------------------------------------------------------------------------
// tb_thermostat_ctrl : scoreboard bench for combinational and registered builds
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_thermostat_ctrl;

  logic clk = 1'b0;
  logic rst_n, mode, too_cold, too_hot, fan_on;
  logic h0, a0, f0;
  logic h1, a1, f1;

  always #5 clk = ~clk;

  thermostat_ctrl #(.OUT_REG(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .mode(mode), .too_cold(too_cold),
    .too_hot(too_hot), .fan_on(fan_on), .heater(h0), .aircon(a0), .fan(f0)
  );

  thermostat_ctrl #(.OUT_REG(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .mode(mode), .too_cold(too_cold),
    .too_hot(too_hot), .fan_on(fan_on), .heater(h1), .aircon(a1), .fan(f1)
  );

  // sel: 0 = combinational instance, 1 = registered instance
  typedef struct {
    string      name;
    bit         sel;
    logic [2:0] exp;
  } exp_t;

  exp_t q_now[$];
  exp_t q_reg[$];
  int   n_vec = 0;
  int   n_err = 0;
  event ev_now;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: heater/aircon/fan got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_excl(input string name, input logic [2:0] act);
    n_vec++;
    if (act[2] & act[1]) begin
      n_err++;
      $display("FAIL %s_excl: heater and aircon both high (got %b, required not both)", name, act);
    end
  endtask

  function automatic logic [2:0] model(input logic m, input logic c, input logic h, input logic f);
    logic hh, aa;
    hh = (m == 1'b1) && c;
    aa = (m == 1'b0) && h;
    return {hh, aa, (hh || aa || f)};
  endfunction

  // Immediate checks: sampled 1 time unit after the stimulus changed.
  initial begin : mon_now
    exp_t       e;
    logic [2:0] act;
    forever begin
      @(ev_now);
      #1;
      while (q_now.size() > 0) begin
        e   = q_now.pop_front();
        act = e.sel ? {h1, a1, f1} : {h0, a0, f0};
        check(e.name, act, e.exp);
        if (!e.sel) check_excl(e.name, act);
      end
    end
  end

  // Registered checks: one entry per cycle, sampled on the falling edge.
  initial begin : mon_reg
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        check(e.name, {h1, a1, f1}, e.exp);
      end
    end
  end

  task automatic apply_now(input string name, input bit sel, input logic m, input logic c,
                           input logic h, input logic f, input logic [2:0] exp);
    exp_t e;
    mode = m; too_cold = c; too_hot = h; fan_on = f;
    e.name = name; e.sel = sel; e.exp = exp;
    q_now.push_back(e);
    ->ev_now;
    #2;
  endtask

  task automatic apply_reg(input string name, input logic rst, input logic m, input logic c,
                           input logic h, input logic f, input logic [2:0] exp);
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = rst; mode = m; too_cold = c; too_hot = h; fan_on = f;
    e.name = name; e.sel = 1'b1; e.exp = exp;
    q_reg.push_back(e);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q_reg.size() > 0 || q_now.size() > 0) && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (q_reg.size() > 0 || q_now.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q_now.size(), q_reg.size());
      q_now.delete();
      q_reg.delete();
    end
  endtask

  initial begin : stim
    logic [3:0] r;
    rst_n = 1'b0; mode = 1'b0; too_cold = 1'b0; too_hot = 1'b0; fan_on = 1'b0;

    // Reset with heating demand present: registered outputs stay 0,
    // combinational outputs ignore rst_n.
    apply_reg("rst_state", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    apply_now("comb_in_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    apply_reg("rst_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    drain();

    apply_now("winter_idle",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    apply_now("winter_cold",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    apply_now("winter_fanreq",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    apply_now("winter_hot",      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    apply_now("winter_hot_fan",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001);
    apply_now("winter_both",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101);
    apply_now("summer_hot",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    apply_now("summer_cold",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    apply_now("summer_all",      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011);
    apply_now("summer_fanreq",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);

    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      r = 4'($urandom_range(0, 15));
      apply_now("sweep_pos", 1'b0, r[3], r[2], r[1], r[0], model(r[3], r[2], r[1], r[0]));
      @(negedge clk);
      r = 4'($urandom_range(0, 15));
      apply_now("sweep_neg", 1'b0, r[3], r[2], r[1], r[0], model(r[3], r[2], r[1], r[0]));
    end
    drain();

    apply_reg("reg_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    apply_reg("reg_lat_heat", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    apply_now("reg_lat_pre", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    apply_reg("reg_cool", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    apply_reg("reg_heat_again", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    apply_reg("reg_rst_mid", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    apply_reg("reg_resume", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    apply_reg("reg_fan_only", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_thermostat_ctrl

`default_nettype wire
